// File: rtl/iiq_pkg.sv
// Shared integer-issue-queue definitions: entry layout and sizing used by the
// shift queue, the dispatch stage and the issue-select controller.
package iiq_pkg;

   localparam int IIQ_N_ENTRIES     = 8;
   localparam int ROB_TAG_WIDTH     = 6;
   localparam int IIQ_PAYLOAD_WIDTH = 16;
   localparam int IIQ_N_CDB         = 2;
   localparam int IIQ_TAG_WIDTH     = ROB_TAG_WIDTH;
   localparam int IIQ_ENTRY_WIDTH   = 2 * (1 + IIQ_TAG_WIDTH) + IIQ_PAYLOAD_WIDTH;

   typedef struct packed {
      logic                         src1_rdy;
      logic [IIQ_TAG_WIDTH-1:0]     src1_tag;
      logic                         src2_rdy;
      logic [IIQ_TAG_WIDTH-1:0]     src2_tag;
      logic [IIQ_PAYLOAD_WIDTH-1:0] payload;
   } iiq_entry_t;

   // Returns the entry with the requested ready bits forced high.
   function automatic iiq_entry_t iiq_set_ready(iiq_entry_t e, logic set1, logic set2);
      iiq_entry_t r;
      r          = e;
      r.src1_rdy = e.src1_rdy | set1;
      r.src2_rdy = e.src2_rdy | set2;
      return r;
   endfunction

endpackage

// File: rtl/prio_enc_lsb.sv
// Lowest-set-bit one-hot picker; an all-zero request yields an all-zero grant.
module prio_enc_lsb #(
   parameter int N = 4
) (
   input  logic [N-1:0] i_req,
   output logic [N-1:0] o_grant
);

   // Two's-complement isolate: req & -req keeps only the lowest set bit.
   assign o_grant = i_req & (~i_req + N'(1));

endmodule

// File: rtl/iiq_issue_select.sv
// IIQ consumer: CDB wakeup of queued operands, oldest-ready select, and the
// valid/ready issue register feeding the integer ALU.
module iiq_issue_select
   import iiq_pkg::*;
#(
   parameter int N_ENTRIES     = IIQ_N_ENTRIES,
   parameter int TAG_WIDTH     = IIQ_TAG_WIDTH,
   parameter int PAYLOAD_WIDTH = IIQ_PAYLOAD_WIDTH,
   parameter int N_CDB         = IIQ_N_CDB,
   parameter int ENTRY_WIDTH   = 2 * (1 + TAG_WIDTH) + PAYLOAD_WIDTH
) (
   input  logic                             clk,
   input  logic                             rst_aL,
   input  logic                             flush,
   input  logic [$clog2(N_ENTRIES):0]       q_count,
   input  logic [N_ENTRIES*ENTRY_WIDTH-1:0] entry_douts,
   output logic                             deq_ready,
   output logic [N_ENTRIES-1:0]             deq_sel_onehot,
   input  logic                             deq_valid,
   input  logic [ENTRY_WIDTH-1:0]           deq_data,
   output logic [N_ENTRIES-1:0]             wr_en,
   output logic [N_ENTRIES*ENTRY_WIDTH-1:0] wr_data,
   input  logic [N_CDB-1:0]                 cdb_valid,
   input  logic [N_CDB*TAG_WIDTH-1:0]       cdb_tag,
   output logic                             iss_valid,
   input  logic                             iss_ready,
   output logic [ENTRY_WIDTH-1:0]           iss_data
);

   // Handshake: the ALU takes iss_data on a cycle where iss_valid & iss_ready;
   // the queue gives up the picked entry on a cycle where deq_ready & deq_valid.

   localparam int EW        = ENTRY_WIDTH;
   localparam int CW        = $clog2(N_ENTRIES) + 1;
   localparam int S1_RDY    = EW - 1;
   localparam int S1_TAG_LO = EW - 1 - TAG_WIDTH;
   localparam int S2_RDY    = TAG_WIDTH + PAYLOAD_WIDTH;
   localparam int S2_TAG_LO = PAYLOAD_WIDTH;

   logic [N_ENTRIES-1:0] w_valid;
   logic [N_ENTRIES-1:0] w_wake1;
   logic [N_ENTRIES-1:0] w_wake2;
   logic [N_ENTRIES-1:0] w_rdy_vec;
   logic [N_ENTRIES-1:0] w_pick;
   logic                 w_slot_free;
   logic                 w_deq;
   logic                 r_iss_valid;
   logic [EW-1:0]        r_iss_data;

   genvar gi, gk;
   for (gi = 0; gi < N_ENTRIES; gi++) begin : g_entry
      logic [EW-1:0]    w_entry;
      logic [EW-1:0]    w_set_mask;
      logic [N_CDB-1:0] w_hit1;
      logic [N_CDB-1:0] w_hit2;

      assign w_entry      = entry_douts[gi*EW +: EW];
      assign w_valid[gi]  = (CW'(gi) < q_count);

      for (gk = 0; gk < N_CDB; gk++) begin : g_cdb
         assign w_hit1[gk] = cdb_valid[gk] &&
            (cdb_tag[gk*TAG_WIDTH +: TAG_WIDTH] == w_entry[S1_TAG_LO +: TAG_WIDTH]);
         assign w_hit2[gk] = cdb_valid[gk] &&
            (cdb_tag[gk*TAG_WIDTH +: TAG_WIDTH] == w_entry[S2_TAG_LO +: TAG_WIDTH]);
      end

      // Only not-yet-ready sources wake; an already-ready source never re-fires wr_en.
      assign w_wake1[gi] = w_valid[gi] & ~w_entry[S1_RDY] & (|w_hit1);
      assign w_wake2[gi] = w_valid[gi] & ~w_entry[S2_RDY] & (|w_hit2);
      assign wr_en[gi]   = w_wake1[gi] | w_wake2[gi];

      assign w_set_mask  = (EW'(w_wake1[gi]) << S1_RDY) | (EW'(w_wake2[gi]) << S2_RDY);
      assign wr_data[gi*EW +: EW] = wr_en[gi] ? (w_entry | w_set_mask) : '0;

      // Select looks at the stored ready bits only, so a wakeup issues one cycle later.
      assign w_rdy_vec[gi] = w_valid[gi] & w_entry[S1_RDY] & w_entry[S2_RDY];
   end

   prio_enc_lsb #(
      .N (N_ENTRIES)
   ) u_pick (
      .i_req   (w_rdy_vec),
      .o_grant (w_pick)
   );

   assign w_slot_free    = ~r_iss_valid | iss_ready;
   assign deq_ready      = w_slot_free & ~flush;
   assign deq_sel_onehot = w_pick & {N_ENTRIES{deq_ready}};
   assign w_deq          = deq_ready & deq_valid;

   always_ff @(posedge clk) begin
      if (!rst_aL) begin
         r_iss_valid <= 1'b0;
         r_iss_data  <= '0;
      end else if (flush) begin
         r_iss_valid <= 1'b0;
      end else if (w_deq) begin
         r_iss_valid <= 1'b1;
         r_iss_data  <= deq_data;
      end else if (iss_ready) begin
         r_iss_valid <= 1'b0;
      end
   end

   assign iss_valid = r_iss_valid;
   assign iss_data  = r_iss_data;

endmodule

// File: tb/tb_iiq_issue_select.sv
// Self-checking bench for iiq_issue_select with a behavioural queue/issue model.
module tb_iiq_issue_select;

   localparam int N  = iiq_pkg::IIQ_N_ENTRIES;
   localparam int TW = iiq_pkg::IIQ_TAG_WIDTH;
   localparam int PW = iiq_pkg::IIQ_PAYLOAD_WIDTH;
   localparam int NC = iiq_pkg::IIQ_N_CDB;
   localparam int EW = 2 * (1 + TW) + PW;
   localparam int CW = $clog2(N) + 1;

   logic              clk;
   logic              rst_aL;
   logic              flush;
   logic [CW-1:0]     q_count;
   logic [N*EW-1:0]   entry_douts;
   logic              deq_ready;
   logic [N-1:0]      deq_sel_onehot;
   logic              deq_valid;
   logic [EW-1:0]     deq_data;
   logic [N-1:0]      wr_en;
   logic [N*EW-1:0]   wr_data;
   logic [NC-1:0]     cdb_valid;
   logic [NC*TW-1:0]  cdb_tag;
   logic              iss_valid;
   logic              iss_ready;
   logic [EW-1:0]     iss_data;

   // queue contents as fields
   logic          e_r1 [N];
   logic [TW-1:0] e_t1 [N];
   logic          e_r2 [N];
   logic [TW-1:0] e_t2 [N];
   logic [PW-1:0] e_pl [N];
   logic          c_v  [NC];
   logic [TW-1:0] c_t  [NC];

   // reference model state and expectations
   logic            m_valid;
   logic [EW-1:0]   m_data;
   logic [N-1:0]    exp_wr_en;
   logic [N*EW-1:0] exp_wr_data;
   logic [N-1:0]    exp_sel;
   logic            exp_deq_ready;
   int              exp_pick;

   int n_tests;
   int n_fail;

   iiq_issue_select dut (
      .clk            (clk),
      .rst_aL         (rst_aL),
      .flush          (flush),
      .q_count        (q_count),
      .entry_douts    (entry_douts),
      .deq_ready      (deq_ready),
      .deq_sel_onehot (deq_sel_onehot),
      .deq_valid      (deq_valid),
      .deq_data       (deq_data),
      .wr_en          (wr_en),
      .wr_data        (wr_data),
      .cdb_valid      (cdb_valid),
      .cdb_tag        (cdb_tag),
      .iss_valid      (iss_valid),
      .iss_ready      (iss_ready),
      .iss_data       (iss_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [EW-1:0] pack(logic r1, logic [TW-1:0] t1, logic r2,
                                          logic [TW-1:0] t2, logic [PW-1:0] pl);
      return {r1, t1, r2, t2, pl};
   endfunction

   always_comb begin
      entry_douts = '0;
      for (int i = 0; i < N; i++)
         entry_douts[i*EW +: EW] = pack(e_r1[i], e_t1[i], e_r2[i], e_t2[i], e_pl[i]);
   end

   always_comb begin
      cdb_valid = '0;
      cdb_tag   = '0;
      for (int k = 0; k < NC; k++) begin
         cdb_valid[k]          = c_v[k];
         cdb_tag[k*TW +: TW]   = c_t[k];
      end
   end

   // queue side: hands over the selected entry in the same cycle
   assign deq_valid = |deq_sel_onehot;
   always_comb begin
      deq_data = '0;
      for (int i = 0; i < N; i++)
         if (deq_sel_onehot[i]) deq_data = entry_douts[i*EW +: EW];
   end

   function automatic logic cdb_hit(logic [TW-1:0] tag);
      logic h;
      h = 1'b0;
      for (int k = 0; k < NC; k++)
         if (c_v[k] && c_t[k] == tag) h = 1'b1;
      return h;
   endfunction

   function automatic void model_comb();
      logic w1, w2;
      exp_wr_en   = '0;
      exp_wr_data = '0;
      exp_sel     = '0;
      exp_pick    = -1;
      for (int i = 0; i < N; i++) begin
         if (i < int'(q_count)) begin
            w1 = !e_r1[i] && cdb_hit(e_t1[i]);
            w2 = !e_r2[i] && cdb_hit(e_t2[i]);
            if (w1 || w2) begin
               exp_wr_en[i] = 1'b1;
               exp_wr_data[i*EW +: EW] = pack(e_r1[i] | w1, e_t1[i], e_r2[i] | w2, e_t2[i], e_pl[i]);
            end
            if (e_r1[i] && e_r2[i] && exp_pick < 0) exp_pick = i;
         end
      end
      exp_deq_ready = (!m_valid || iss_ready) && !flush;
      if (exp_pick >= 0 && exp_deq_ready) exp_sel[exp_pick] = 1'b1;
   endfunction

   task automatic tick();
      logic          nv;
      logic [EW-1:0] nd;
      model_comb();
      nv = m_valid;
      nd = m_data;
      if (!rst_aL) begin
         nv = 1'b0;
         nd = '0;
      end else if (flush) begin
         nv = 1'b0;
      end else if (exp_sel != '0) begin
         nv = 1'b1;
         nd = pack(e_r1[exp_pick], e_t1[exp_pick], e_r2[exp_pick], e_t2[exp_pick], e_pl[exp_pick]);
      end else if (iss_ready) begin
         nv = 1'b0;
      end
      @(posedge clk);
      m_valid = nv;
      m_data  = nd;
      @(negedge clk);
   endtask

   task automatic clear_entries();
      for (int i = 0; i < N; i++) begin
         e_r1[i] = 1'b0;
         e_t1[i] = TW'(60);
         e_r2[i] = 1'b0;
         e_t2[i] = TW'(61);
         e_pl[i] = PW'($urandom);
      end
      for (int k = 0; k < NC; k++) begin
         c_v[k] = 1'b0;
         c_t[k] = '0;
      end
   endtask

   task automatic test_reset();
      clear_entries();
      for (int i = 0; i < 3; i++) begin
         e_r1[i] = 1'b1;
         e_r2[i] = 1'b1;
      end
      q_count   = CW'(3);
      rst_aL    = 1'b0;
      flush     = 1'b0;
      iss_ready = 1'b0;
      tick();
      n_tests++;
      if (iss_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_iss_valid: got %b want 0", iss_valid);
      end
      n_tests++;
      if (iss_data !== '0) begin
         n_fail++;
         $display("FAIL reset_iss_data: got %h want 0", iss_data);
      end
      rst_aL    = 1'b1;
      iss_ready = 1'b1;
      #1;
      n_tests++;
      if (deq_sel_onehot !== N'(1)) begin
         n_fail++;
         $display("FAIL reset_first_sel: got %b want %b", deq_sel_onehot, N'(1));
      end
      tick();
      n_tests++;
      if (iss_valid !== 1'b1 || iss_data !== pack(1'b1, e_t1[0], 1'b1, e_t2[0], e_pl[0])) begin
         n_fail++;
         $display("FAIL reset_then_issue: got v=%b d=%h want v=1 d=%h", iss_valid, iss_data,
                  pack(1'b1, e_t1[0], 1'b1, e_t2[0], e_pl[0]));
      end
   endtask

   task automatic test_select();
      clear_entries();
      e_r2[0] = 1'b1;
      for (int i = 1; i < 3; i++) begin
         e_r1[i] = 1'b1;
         e_r2[i] = 1'b1;
      end
      q_count   = CW'(3);
      iss_ready = 1'b1;
      #1;
      n_tests++;
      if (deq_ready !== 1'b1 || deq_sel_onehot !== N'(2)) begin
         n_fail++;
         $display("FAIL select_pick: got rdy=%b sel=%b want rdy=1 sel=%b", deq_ready, deq_sel_onehot, N'(2));
      end
      tick();
      n_tests++;
      if (iss_valid !== 1'b1 || iss_data !== pack(1'b1, e_t1[1], 1'b1, e_t2[1], e_pl[1])) begin
         n_fail++;
         $display("FAIL select_issue: got v=%b d=%h want v=1 d=%h", iss_valid, iss_data,
                  pack(1'b1, e_t1[1], 1'b1, e_t2[1], e_pl[1]));
      end
   endtask

   task automatic test_wakeup();
      logic [EW-1:0] want;
      clear_entries();
      e_t1[0] = TW'(5);
      e_r2[0] = 1'b1;
      e_t2[0] = TW'(20);
      for (int i = 1; i < 3; i++) begin
         e_t1[i] = TW'(40);
         e_r2[i] = 1'b1;
      end
      q_count   = CW'(3);
      iss_ready = 1'b1;
      c_v[0]    = 1'b1;
      c_t[0]    = TW'(5);
      c_t[1]    = TW'(40);
      #1;
      want = pack(1'b1, TW'(5), 1'b1, TW'(20), e_pl[0]);
      n_tests++;
      if (wr_en !== N'(1) || wr_data[EW-1:0] !== want) begin
         n_fail++;
         $display("FAIL wakeup_write: got en=%b d=%h want en=%b d=%h", wr_en, wr_data[EW-1:0], N'(1), want);
      end
      n_tests++;
      if (deq_sel_onehot !== '0) begin
         n_fail++;
         $display("FAIL wakeup_no_bypass: got sel=%b want 0", deq_sel_onehot);
      end
      tick();
      e_r1[0] = 1'b1;
      c_v[0]  = 1'b0;
      #1;
      n_tests++;
      if (wr_en !== '0 || deq_sel_onehot !== N'(1)) begin
         n_fail++;
         $display("FAIL wakeup_next_sel: got en=%b sel=%b want en=0 sel=%b", wr_en, deq_sel_onehot, N'(1));
      end
      tick();
      n_tests++;
      if (iss_valid !== 1'b1 || iss_data !== want) begin
         n_fail++;
         $display("FAIL wakeup_issue: got v=%b d=%h want v=1 d=%h", iss_valid, iss_data, want);
      end
   endtask

   task automatic test_back_to_back();
      logic [EW-1:0] held;
      clear_entries();
      for (int i = 0; i < 4; i++) begin
         e_r1[i] = 1'b1;
         e_r2[i] = 1'b1;
      end
      q_count   = CW'(4);
      iss_ready = 1'b1;
      tick();
      held      = pack(1'b1, e_t1[0], 1'b1, e_t2[0], e_pl[0]);
      e_r1[0]   = 1'b0;
      iss_ready = 1'b0;
      #1;
      n_tests++;
      if (deq_ready !== 1'b0 || deq_sel_onehot !== '0) begin
         n_fail++;
         $display("FAIL bp_stall: got rdy=%b sel=%b want rdy=0 sel=0", deq_ready, deq_sel_onehot);
      end
      tick();
      n_tests++;
      if (iss_valid !== 1'b1 || iss_data !== held) begin
         n_fail++;
         $display("FAIL bp_hold: got v=%b d=%h want v=1 d=%h", iss_valid, iss_data, held);
      end
      iss_ready = 1'b1;
      #1;
      n_tests++;
      if (deq_ready !== 1'b1 || deq_sel_onehot !== N'(2)) begin
         n_fail++;
         $display("FAIL b2b_sel: got rdy=%b sel=%b want rdy=1 sel=%b", deq_ready, deq_sel_onehot, N'(2));
      end
      tick();
      n_tests++;
      if (iss_valid !== 1'b1 || iss_data !== pack(1'b1, e_t1[1], 1'b1, e_t2[1], e_pl[1])) begin
         n_fail++;
         $display("FAIL b2b_replace: got v=%b d=%h want v=1 d=%h", iss_valid, iss_data,
                  pack(1'b1, e_t1[1], 1'b1, e_t2[1], e_pl[1]));
      end
   endtask

   task automatic test_flush();
      clear_entries();
      for (int i = 0; i < 2; i++) begin
         e_r1[i] = 1'b1;
         e_r2[i] = 1'b1;
      end
      e_t1[2]   = TW'(9);
      e_r2[2]   = 1'b1;
      q_count   = CW'(3);
      iss_ready = 1'b1;
      tick();
      iss_ready = 1'b0;
      flush     = 1'b1;
      c_v[1]    = 1'b1;
      c_t[1]    = TW'(9);
      #1;
      n_tests++;
      if (deq_ready !== 1'b0 || deq_sel_onehot !== '0 || wr_en !== N'(4)) begin
         n_fail++;
         $display("FAIL flush_comb: got rdy=%b sel=%b en=%b want rdy=0 sel=0 en=%b",
                  deq_ready, deq_sel_onehot, wr_en, N'(4));
      end
      tick();
      n_tests++;
      if (iss_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_drop: got v=%b want 0", iss_valid);
      end
      flush = 1'b0;
   endtask

   task automatic test_bounds();
      logic [EW-1:0] want;
      clear_entries();
      for (int i = 0; i < N; i++) begin
         e_r1[i] = 1'b1;
         e_r2[i] = 1'b1;
      end
      e_r1[3]   = 1'b0;
      e_t1[3]   = TW'(11);
      c_v[0]    = 1'b1;
      c_t[0]    = TW'(11);
      q_count   = '0;
      iss_ready = 1'b1;
      #1;
      n_tests++;
      if (deq_sel_onehot !== '0 || wr_en !== '0 || wr_data !== '0) begin
         n_fail++;
         $display("FAIL empty_queue: got sel=%b en=%b want sel=0 en=0 data=0", deq_sel_onehot, wr_en);
      end
      tick();
      clear_entries();
      e_r1[N-1] = 1'b1;
      e_r2[N-1] = 1'b1;
      q_count   = CW'(N);
      #1;
      n_tests++;
      if (deq_sel_onehot !== (N'(1) << (N - 1))) begin
         n_fail++;
         $display("FAIL full_last: got sel=%b want %b", deq_sel_onehot, N'(1) << (N - 1));
      end
      tick();
      n_tests++;
      if (iss_valid !== 1'b1 || iss_data !== pack(1'b1, e_t1[N-1], 1'b1, e_t2[N-1], e_pl[N-1])) begin
         n_fail++;
         $display("FAIL full_last_issue: got v=%b d=%h", iss_valid, iss_data);
      end
      clear_entries();
      e_t1[0] = TW'(3);
      e_t2[0] = TW'(7);
      c_v[0]  = 1'b1;
      c_t[0]  = TW'(3);
      c_v[1]  = 1'b1;
      c_t[1]  = TW'(7);
      q_count = CW'(1);
      #1;
      want = pack(1'b1, TW'(3), 1'b1, TW'(7), e_pl[0]);
      n_tests++;
      if (wr_en !== N'(1) || wr_data[EW-1:0] !== want || deq_sel_onehot !== '0) begin
         n_fail++;
         $display("FAIL dual_wake: got en=%b d=%h sel=%b want en=%b d=%h sel=0",
                  wr_en, wr_data[EW-1:0], deq_sel_onehot, N'(1), want);
      end
      tick();
   endtask

   task automatic test_random();
      for (int it = 0; it < 400; it++) begin
         for (int i = 0; i < N; i++) begin
            e_r1[i] = ($urandom_range(0, 2) == 0);
            e_t1[i] = TW'($urandom_range(0, 7));
            e_r2[i] = ($urandom_range(0, 2) == 0);
            e_t2[i] = TW'($urandom_range(0, 7));
            e_pl[i] = PW'($urandom);
         end
         for (int k = 0; k < NC; k++) begin
            c_v[k] = ($urandom_range(0, 1) == 1);
            c_t[k] = TW'($urandom_range(0, 7));
         end
         q_count   = CW'($urandom_range(0, N));
         flush     = ($urandom_range(0, 7) == 0);
         iss_ready = ($urandom_range(0, 2) != 0);
         rst_aL    = ($urandom_range(0, 49) != 0);
         #1;
         model_comb();
         n_tests++;
         if (wr_en !== exp_wr_en || wr_data !== exp_wr_data) begin
            n_fail++;
            $display("FAIL rand_wakeup it=%0d: got en=%b want en=%b", it, wr_en, exp_wr_en);
         end
         n_tests++;
         if (deq_ready !== exp_deq_ready || deq_sel_onehot !== exp_sel) begin
            n_fail++;
            $display("FAIL rand_select it=%0d: got rdy=%b sel=%b want rdy=%b sel=%b",
                     it, deq_ready, deq_sel_onehot, exp_deq_ready, exp_sel);
         end
         tick();
         n_tests++;
         if (iss_valid !== m_valid || iss_data !== m_data) begin
            n_fail++;
            $display("FAIL rand_issue it=%0d: got v=%b d=%h want v=%b d=%h",
                     it, iss_valid, iss_data, m_valid, m_data);
         end
      end
      rst_aL = 1'b1;
      flush  = 1'b0;
   endtask

   initial begin
      n_tests   = 0;
      n_fail    = 0;
      m_valid   = 1'b0;
      m_data    = '0;
      rst_aL    = 1'b0;
      flush     = 1'b0;
      iss_ready = 1'b0;
      q_count   = '0;
      clear_entries();
      @(negedge clk);
      test_reset();
      test_select();
      test_wakeup();
      test_back_to_back();
      test_flush();
      test_bounds();
      test_random();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
